// File: rtl/axi4_pkg.sv
// ---------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4 types and helpers for the SRAM responder and its address
// generator.
//   axi4_burst_t   : AxBURST encodings (2'b11 is reserved and handled as INCR)
//   axi4_resp_t    : xRESP encodings
//   axi4_beat_log2 : log2 of bytes per data beat for a given bus width
// ---------------------------------------------------------------------------
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } axi4_burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi4_resp_t;

    localparam int AXI4_LEN_WIDTH   = 8;
    localparam int AXI4_SIZE_WIDTH  = 3;
    localparam int AXI4_BURST_WIDTH = 2;
    localparam int AXI4_RESP_WIDTH  = 2;

    function automatic int axi4_beat_log2(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4_if.sv
// ---------------------------------------------------------------------------
// axi4_if
// AXI4 channel bundle (AW/W/B/AR/R) without the optional sideband signals.
//   modport master : drives AW/W/AR valid+payload, BREADY, RREADY
//   modport slave  : drives AWREADY, WREADY, B channel, ARREADY, R channel
// ---------------------------------------------------------------------------
interface axi4_if #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 128,
    parameter int AXI4_ID_WIDTH      = 4
);
    logic [AXI4_ID_WIDTH-1:0]        awid;
    logic [AXI4_ADDRESS_WIDTH-1:0]   awaddr;
    logic [7:0]                      awlen;
    logic [2:0]                      awsize;
    logic [1:0]                      awburst;
    logic                            awvalid;
    logic                            awready;

    logic [AXI4_DATA_WIDTH-1:0]      wdata;
    logic [AXI4_DATA_WIDTH/8-1:0]    wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;

    logic [AXI4_ID_WIDTH-1:0]        bid;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;

    logic [AXI4_ID_WIDTH-1:0]        arid;
    logic [AXI4_ADDRESS_WIDTH-1:0]   araddr;
    logic [7:0]                      arlen;
    logic [2:0]                      arsize;
    logic [1:0]                      arburst;
    logic                            arvalid;
    logic                            arready;

    logic [AXI4_ID_WIDTH-1:0]        rid;
    logic [AXI4_DATA_WIDTH-1:0]      rdata;
    logic [1:0]                      rresp;
    logic                            rlast;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi4_burst_addr_gen
// Combinational next-beat address for an AXI4 burst.
//   addr      : current beat address
//   len       : AxLEN (beats - 1), used for the WRAP boundary
//   size      : AxSIZE, clamped to the full bus width
//   burst     : AxBURST; reserved 2'b11 behaves as INCR
//   next_addr : address of the following beat (wraps at ADDRESS_WIDTH bits)
// ---------------------------------------------------------------------------
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 128
) (
    input  logic [AXI4_ADDRESS_WIDTH-1:0] addr,
    input  logic [7:0]                    len,
    input  logic [2:0]                    size,
    input  logic [1:0]                    burst,
    output logic [AXI4_ADDRESS_WIDTH-1:0] next_addr
);

    localparam int         AW       = AXI4_ADDRESS_WIDTH;
    localparam logic [2:0] MAX_SIZE = 3'(axi4_beat_log2(AXI4_DATA_WIDTH));

    logic [2:0]    size_eff;
    logic [AW-1:0] beat_bytes;
    logic [AW-1:0] wrap_bytes;
    logic [AW-1:0] incr_addr;
    logic [AW-1:0] wrap_addr;

    always_comb begin
        size_eff   = (size > MAX_SIZE) ? MAX_SIZE : size;
        beat_bytes = AW'(1) << size_eff;
        wrap_bytes = (AW'(len) + AW'(1)) << size_eff;
        // INCR aligns first so an unaligned start lands on the next beat boundary
        incr_addr  = (addr & ~(beat_bytes - AW'(1))) + beat_bytes;
        wrap_addr  = (addr & ~(wrap_bytes - AW'(1)))
                   | ((addr + beat_bytes) & (wrap_bytes - AW'(1)));
        case (burst)
            FIXED:   next_addr = addr;
            WRAP:    next_addr = wrap_addr;
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// ---------------------------------------------------------------------------
// axi4_sram_slave
// AXI4 responder backed by an internal byte-lane-writable memory. Write and
// read channels run independently with one outstanding burst each.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset (memory contents are not reset)
//   s    : axi4_if.slave port (AW/W/B/AR/R)
// Build option: define AXI4_SRAM_SLVERR_EN to answer bursts whose start
// address lies above the memory range with SLVERR (writes dropped, reads
// return zero). Without it, upper address bits alias onto the memory.
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, storing beats until AWLEN+1 have been taken
// W_RESP | BVALID high, waiting for BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, presenting beats until the RLAST handshake
// ---------------------------------------------------------------------------
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 128,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int MEM_ADDR_BITS      = 16
) (
    input logic   clk,
    input logic   rstn,
    axi4_if.slave s
);

    localparam int AW        = AXI4_ADDRESS_WIDTH;
    localparam int DW        = AXI4_DATA_WIDTH;
    localparam int IW        = AXI4_ID_WIDTH;
    localparam int NBYTES    = DW / 8;
    localparam int BEAT_LOG2 = axi4_beat_log2(DW);
    localparam int IDX_W     = MEM_ADDR_BITS - BEAT_LOG2;
    localparam int DEPTH     = 2 ** IDX_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    logic [DW-1:0] mem [DEPTH];

    logic aw_oor;
    logic ar_oor;

`ifdef AXI4_SRAM_SLVERR_EN
    assign aw_oor = |s.awaddr[AW-1:MEM_ADDR_BITS];
    assign ar_oor = |s.araddr[AW-1:MEM_ADDR_BITS];
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Burst end is taken from the beat counter, so WLAST carries no information.
    logic unused_wlast;
    assign unused_wlast = s.wlast;

    // ---------------- write channel ----------------
    wr_state_t     wr_state_q, wr_state_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          bvalid_q, bvalid_d;
    logic [IW-1:0] bid_q, bid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [IW-1:0] wid_q, wid_d;
    logic [AW-1:0] waddr_q, waddr_d, waddr_next;
    logic [7:0]    wlen_q, wlen_d;
    logic [2:0]    wsize_q, wsize_d;
    logic [1:0]    wburst_q, wburst_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          werr_q, werr_d;
    logic          mem_we;

    axi4_burst_addr_gen #(
        .AXI4_ADDRESS_WIDTH (AW),
        .AXI4_DATA_WIDTH    (DW)
    ) u_wr_addr_gen (
        .addr      (waddr_q),
        .len       (wlen_q),
        .size      (wsize_q),
        .burst     (wburst_q),
        .next_addr (waddr_next)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        mem_we     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s.awvalid && awready_q) begin
                    wid_d      = s.awid;
                    waddr_d    = s.awaddr;
                    wlen_d     = s.awlen;
                    wsize_d    = s.awsize;
                    wburst_d   = s.awburst;
                    werr_d     = aw_oor;
                    wcnt_d     = '0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s.wvalid && wready_q) begin
                    mem_we  = !werr_q;
                    waddr_d = waddr_next;
                    wcnt_d  = wcnt_q + 8'd1;
                    if (wcnt_q == wlen_q) begin
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        bid_d      = wid_q;
                        bresp_d    = werr_q ? SLVERR : OKAY;
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s.bready && bvalid_q) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= '0;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            wid_q      <= wid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wsize_q    <= wsize_d;
            wburst_q   <= wburst_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
        end
    end

    logic [IDX_W-1:0] widx;
    assign widx = waddr_q[MEM_ADDR_BITS-1:BEAT_LOG2];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (s.wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= s.wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_t        rd_state_q, rd_state_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic             rlast_q, rlast_d;
    logic [IW-1:0]    rid_q, rid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [DW-1:0]    rdata_q;
    logic [AW-1:0]    raddr_q, raddr_d, raddr_next;
    logic [7:0]       rlen_q, rlen_d;
    logic [2:0]       rsize_q, rsize_d;
    logic [1:0]       rburst_q, rburst_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             rerr_q, rerr_d;
    logic             rd_load;
    logic             rd_zero;
    logic [IDX_W-1:0] rd_idx;

    axi4_burst_addr_gen #(
        .AXI4_ADDRESS_WIDTH (AW),
        .AXI4_DATA_WIDTH    (DW)
    ) u_rd_addr_gen (
        .addr      (raddr_q),
        .len       (rlen_q),
        .size      (rsize_q),
        .burst     (rburst_q),
        .next_addr (raddr_next)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rid_d      = rid_q;
        rresp_d    = rresp_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rcnt_d     = rcnt_q;
        rerr_d     = rerr_q;
        rd_load    = 1'b0;
        rd_zero    = rerr_q;
        rd_idx     = raddr_next[MEM_ADDR_BITS-1:BEAT_LOG2];
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s.arvalid && arready_q) begin
                    rid_d      = s.arid;
                    raddr_d    = s.araddr;
                    rlen_d     = s.arlen;
                    rsize_d    = s.arsize;
                    rburst_d   = s.arburst;
                    rerr_d     = ar_oor;
                    rresp_d    = ar_oor ? SLVERR : OKAY;
                    rcnt_d     = '0;
                    rlast_d    = (s.arlen == 8'd0);
                    rvalid_d   = 1'b1;
                    arready_d  = 1'b0;
                    rd_load    = 1'b1;
                    rd_zero    = ar_oor;
                    rd_idx     = s.araddr[MEM_ADDR_BITS-1:BEAT_LOG2];
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && s.rready) begin
                    if (rlast_q) begin
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                        arready_d  = 1'b1;
                        rd_state_d = R_IDLE;
                    end else begin
                        // fetch the following beat in the same edge as the handshake
                        raddr_d = raddr_next;
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                        rd_load = 1'b1;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rresp_q    <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rcnt_q     <= '0;
            rerr_q     <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
            rresp_q    <= rresp_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rsize_q    <= rsize_d;
            rburst_q   <= rburst_d;
            rcnt_q     <= rcnt_d;
            rerr_q     <= rerr_d;
        end
    end

    // Reading mem with the non-blocking write pending gives pre-write data
    // when both channels touch the same word in one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (rd_load) begin
            rdata_q <= rd_zero ? '0 : mem[rd_idx];
        end
    end

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bid     = bid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rlast   = rlast_q;
    assign s.rid     = rid_q;
    assign s.rresp   = rresp_q;
    assign s.rdata   = rdata_q;

endmodule
